// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with per-register pending (scoreboard) flags.
// Reads are registered, write-first bypassed, and suppressed on a pending register.
module reg_file_2r1w #(
    parameter int BIT      = 8,
    parameter int SZB      = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          we,
    input  logic [SZB-1:0]                waddr,
    input  logic [BIT-1:0]                din,
    input  logic                          lock,
    input  logic [SZB-1:0]                laddr,
    input  logic                          re_a,
    input  logic [SZB-1:0]                raddr_a,
    input  logic                          re_b,
    input  logic [SZB-1:0]                raddr_b,
    output logic [BIT-1:0]                dout_a,
    output logic [BIT-1:0]                dout_b,
    output logic                          rvalid_a,
    output logic                          rvalid_b,
    output logic                          hazard,
    output logic [(2**SZB)-1:0]           pend,
    output logic [(2**SZB)*BIT-1:0]       testreg
);

    localparam int SZA = 2**SZB;

    logic [BIT-1:0] regf [SZA];
    logic [SZA-1:0] pend_nxt;
    logic           wr_ok;
    logic           haz_a_p0;
    logic           haz_b_p0;
    logic [BIT-1:0] rd_a_p0;
    logic [BIT-1:0] rd_b_p0;

    // A write to register 0 is dropped when it is hardwired to zero.
    assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    function automatic logic [BIT-1:0] rd_sel(
        input logic [SZB-1:0] ra,
        input logic [BIT-1:0] mem_val
    );
        if ((ZERO_REG != 0) && (ra == '0))
            return '0;
        else if (we && (waddr == ra))
            return din;
        else
            return mem_val;
    endfunction

    // Stage p0: combinational read select, hazard and pending update
    assign rd_a_p0  = rd_sel(raddr_a, regf[raddr_a]);
    assign rd_b_p0  = rd_sel(raddr_b, regf[raddr_b]);
    assign haz_a_p0 = re_a && pend[raddr_a] && !(we && (waddr == raddr_a));
    assign haz_b_p0 = re_b && pend[raddr_b] && !(we && (waddr == raddr_b));
    assign hazard   = haz_a_p0 || haz_b_p0;

    // A lock on the same edge as the write keeps the register pending.
    always_comb begin
        pend_nxt = pend;
        if (we)
            pend_nxt[waddr] = 1'b0;
        if (lock)
            pend_nxt[laddr] = 1'b1;
        if (ZERO_REG != 0)
            pend_nxt[0] = 1'b0;
    end

    // Stage p1: registered state and read outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SZA; i++)
                regf[i] <= '0;
            pend     <= '0;
            dout_a   <= '0;
            dout_b   <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            if (wr_ok)
                regf[waddr] <= din;
            pend     <= pend_nxt;
            rvalid_a <= re_a && !haz_a_p0;
            rvalid_b <= re_b && !haz_b_p0;
            if (re_a && !haz_a_p0)
                dout_a <= rd_a_p0;
            if (re_b && !haz_b_p0)
                dout_b <= rd_b_p0;
        end
    end

    for (genvar g = 0; g < SZA; g++) begin : g_testreg
        assign testreg[BIT*g +: BIT] = regf[g];
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: behavioural model compared every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_reg_file_2r1w;

    logic         clock = 1'b0;
    logic         reset;
    logic         we;
    logic [3:0]   waddr;
    logic [7:0]   din;
    logic         lock;
    logic [3:0]   laddr;
    logic         re_a;
    logic [3:0]   raddr_a;
    logic         re_b;
    logic [3:0]   raddr_b;
    logic [7:0]   dout_a;
    logic [7:0]   dout_b;
    logic         rvalid_a;
    logic         rvalid_b;
    logic         hazard;
    logic [15:0]  pend;
    logic [127:0] testreg;

    int checks = 0;
    int errors = 0;

    reg_file_2r1w #(.BIT(8), .SZB(4), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset), .we(we), .waddr(waddr), .din(din),
        .lock(lock), .laddr(laddr), .re_a(re_a), .raddr_a(raddr_a),
        .re_b(re_b), .raddr_b(raddr_b), .dout_a(dout_a), .dout_b(dout_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .hazard(hazard),
        .pend(pend), .testreg(testreg)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [7:0]  m_mem [16];
    logic [15:0] m_pend;
    logic [7:0]  m_da, m_db;
    logic        m_va, m_vb;

    function automatic logic [7:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return 8'h00;
        if (we && waddr == a) return din;
        return m_mem[a];
    endfunction

    function automatic logic m_haz(input logic r, input logic [3:0] a);
        return r && m_pend[a] && !(we && waddr == a);
    endfunction

    function automatic logic [127:0] m_pack();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = m_mem[i];
        return v;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_pend = '0;
            m_da = 8'h00; m_db = 8'h00; m_va = 1'b0; m_vb = 1'b0;
        end else begin
            logic ha, hb;
            ha = m_haz(re_a, raddr_a);
            hb = m_haz(re_b, raddr_b);
            m_va = re_a && !ha;
            m_vb = re_b && !hb;
            if (m_va) m_da = m_read(raddr_a);
            if (m_vb) m_db = m_read(raddr_b);
            if (we && waddr != 4'd0) m_mem[waddr] = din;
            if (we) m_pend[waddr] = 1'b0;
            if (lock) m_pend[laddr] = 1'b1;
            m_pend[0] = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clock) begin
        chk("m_dout_a", dout_a, m_da);
        chk("m_dout_b", dout_b, m_db);
        chk("m_rvalid_a", rvalid_a, m_va);
        chk("m_rvalid_b", rvalid_b, m_vb);
        chk("m_hazard", hazard, reset ? 1'b0 : (m_haz(re_a, raddr_a) || m_haz(re_b, raddr_b)));
        chk("m_pend", pend, m_pend);
        chk("m_testreg", testreg, m_pack());
    end

    task automatic drive(input logic w, input logic [3:0] wa, input logic [7:0] d,
                         input logic l, input logic [3:0] la,
                         input logic ra, input logic [3:0] aa,
                         input logic rb, input logic [3:0] ab);
        we = w; waddr = wa; din = d; lock = l; laddr = la;
        re_a = ra; raddr_a = aa; re_b = rb; raddr_b = ab;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        chk("rst_dout_a", dout_a, 8'h00);
        chk("rst_rvalid_b", rvalid_b, 1'b0);
        chk("rst_pend", pend, 16'h0000);
        chk("rst_testreg", testreg, 128'h0);
        reset = 1'b0;

        // Write then read register 3
        drive(1, 3, 8'hA5, 0, 0, 0, 0, 0, 0); step();
        chk("wr3_testreg", testreg[31:24], 8'hA5);
        drive(0, 0, 0, 0, 0, 1, 3, 0, 0); step();
        chk("rd3_dout_a", dout_a, 8'hA5);
        chk("rd3_rvalid_a", rvalid_a, 1'b1);

        // Same-edge write with both ports reading it
        drive(1, 5, 8'h3C, 0, 0, 1, 5, 1, 5); step();
        chk("byp_dout_a", dout_a, 8'h3C);
        chk("byp_dout_b", dout_b, 8'h3C);
        chk("byp_rvalid_ab", {rvalid_a, rvalid_b}, 2'b11);

        // Lock 7, read it (hazard), then write-and-read (bypass clears)
        drive(0, 0, 0, 1, 7, 0, 0, 0, 0); step();
        chk("lock7_pend", pend[7], 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("haz7_hazard", hazard, 1'b1);
        step();
        chk("haz7_rvalid_b", rvalid_b, 1'b0);
        chk("haz7_dout_b_held", dout_b, 8'h3C);
        drive(1, 7, 8'h11, 0, 0, 0, 0, 1, 7);
        chk("wr7_hazard", hazard, 1'b0);
        step();
        chk("wr7_dout_b", dout_b, 8'h11);
        chk("wr7_rvalid_b", rvalid_b, 1'b1);
        chk("wr7_pend", pend[7], 1'b0);

        // Lock and write same register on the same edge
        drive(1, 2, 8'h44, 1, 2, 0, 0, 0, 0); step();
        chk("lw2_testreg", testreg[23:16], 8'h44);
        chk("lw2_pend", pend[2], 1'b1);

        // Hazard on port A only; port B proceeds
        drive(0, 0, 0, 0, 0, 1, 2, 1, 3);
        chk("haz2_hazard", hazard, 1'b1);
        step();
        chk("haz2_rvalid_a", rvalid_a, 1'b0);
        chk("haz2_dout_a_held", dout_a, 8'h3C);
        chk("haz2_rvalid_b", rvalid_b, 1'b1);
        chk("haz2_dout_b", dout_b, 8'hA5);

        // Register 0 is hardwired zero
        drive(1, 0, 8'hFF, 1, 0, 0, 0, 1, 0); step();
        chk("z0_pend", pend[0], 1'b0);
        chk("z0_testreg", testreg[7:0], 8'h00);
        chk("z0_dout_b", dout_b, 8'h00);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("z0_hazard", hazard, 1'b0);
        step();
        chk("z0_dout_a", dout_a, 8'h00);
        chk("z0_rvalid_a", rvalid_a, 1'b1);

        // Mixed traffic over a small address range, checked by the model
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
            step();
        end

        // Asynchronous reset mid-cycle after writes and locks
        drive(1, 9, 8'h5A, 1, 10, 1, 9, 1, 9); step();
        drive(0, 0, 0, 1, 11, 1, 10, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_dout", {dout_a, dout_b}, 16'h0000);
        chk("arst_rvalid", {rvalid_a, rvalid_b}, 2'b00);
        chk("arst_pend", pend, 16'h0000);
        chk("arst_testreg", testreg, 128'h0);
        chk("arst_hazard", hazard, 1'b0);
        #4 reset = 1'b0;

        // First edge after reset operates normally
        drive(1, 4, 8'h77, 0, 0, 1, 4, 0, 0); step();
        chk("post_dout_a", dout_a, 8'h77);
        chk("post_testreg", testreg[39:32], 8'h77);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
